traffic_timer: RTL and testbench
================================

# traffic_timer

Interval timer directly upstream of the traffic-light next-state logic: it produces the short-timeout (TS) and long-timeout (TL) qualifiers the FSM uses to leave each light phase. It watches the FSM's current-state bus and restarts itself on every phase change, so each phase is timed from zero. It prescales the system clock into ticks and counts ticks up to a saturating limit.

## Interface
Parameters:
- PRESCALE, 50000000: clock cycles per tick; ≥ 2.
- SHORT_TICKS, 5: ticks until TS_o asserts; ≥ 1.
- LONG_TICKS, 25: ticks until TL_o asserts; SHORT_TICKS < LONG_TICKS < 2^CNT_W.
- CNT_W, 8: tick-counter width.

Ports:
- Clk_i  in  1  system clock, rising edge.
- Rst_i  in  1  reset; asynchronous, active-high.
- Enable_i  in  1  timer enable; low forces IDLE.
- Restart_i  in  1  explicit restart request, one-cycle pulse.
- CurrentState_i  in  2  phase code from the FSM state register (S0..S3 = 00..11).
- TS_o  out  1  short timeout reached, level.
- TL_o  out  1  long timeout reached, level.
- TickCount_o  out  CNT_W  elapsed ticks in the current phase.
- Busy_o  out  1  high in RUN.

## Operation
- Internal state: timer FSM {IDLE, RUN, EXPIRED}, prescaler counter (0..PRESCALE-1), tick counter (0..LONG_TICKS), PrevState register (2 bits).
- PrevState is loaded with CurrentState_i every cycle. StateChange = (CurrentState_i != PrevState), combinational.
- Restart = StateChange | Restart_i.
- Transitions, in priority order:
  - Any state with Enable_i = 0 → IDLE. Prescaler and tick counter clear.
  - IDLE with Enable_i = 1 → RUN. Counters clear.
  - RUN or EXPIRED with Restart → RUN. Counters clear.
  - RUN with tick and tick counter = LONG_TICKS-1 → EXPIRED. Counter becomes LONG_TICKS.
- In RUN, a tick occurs when prescaler = PRESCALE-1. The prescaler wraps to 0 and the tick counter increments.
- EXPIRED holds the prescaler at 0 and the tick counter at LONG_TICKS (saturation, no wrap).
- TS_o = (count ≥ SHORT_TICKS) & ~StateChange & (state ≠ IDLE).
- TL_o = (count ≥ LONG_TICKS) & ~StateChange & (state ≠ IDLE).
- Masking TS_o/TL_o with StateChange stops the FSM from consuming a stale timeout in the first cycle of a new phase.
- TickCount_o = tick counter; Busy_o = (state == RUN).

## Timing
- Reset values: FSM IDLE, all counters 0, PrevState 00. TS_o, TL_o, Busy_o = 0; TickCount_o = 0.
- Reset is asynchronous: it takes effect immediately, including mid-count or while EXPIRED.
- Latency from entering RUN (with no restart) to TS_o high: SHORT_TICKS × PRESCALE cycles.
- Latency from entering RUN to TL_o high: LONG_TICKS × PRESCALE cycles.
- A phase change drops TS_o/TL_o in the same cycle as CurrentState_i changes (combinational). The registered count is 0 from the next edge.
- Restart coincident with a tick: restart wins and the count becomes 0.
- Enable_i low coincident with Restart: IDLE wins.
- Restart_i held high for multiple cycles keeps the counters at 0.
- Outputs are glitch-free only relative to Clk_i. CurrentState_i must be synchronous to Clk_i.

## Structure
- Shared package traffic_pkg:
  - Phase encodings S0..S3, identical to the FSM's.
  - Timer-state encodings IDLE = 2'b00, RUN = 2'b01, EXPIRED = 2'b10.
- Sub-module tick_gen: parameterised prescaler with inputs Clk_i, Rst_i, Clear_i, Run_i and a one-cycle Tick_o pulse.
- Change detection, the timer FSM and the tick counter stay in traffic_timer.

## Test plan
All scenarios use PRESCALE=4, SHORT_TICKS=2, LONG_TICKS=5, CNT_W=8.
1. Rst_i released, Enable_i=1, CurrentState_i=00 held → Busy_o=1; TS_o rises 8 cycles after RUN entry and TL_o rises 20 cycles after; TickCount_o stays at 5 and Busy_o=0 (EXPIRED) for 100 more cycles.
2. Wait until TL_o=1, then change CurrentState_i 00→01 → TS_o=TL_o=0 in that same cycle; TickCount_o=0 next cycle; TS_o rises again 8 cycles later.
3. Restart_i pulse in the same cycle as a tick while TickCount_o=1 → TickCount_o=0 after the edge, not 2.
4. Enable_i dropped at TickCount_o=3 → IDLE, TS_o=0, TickCount_o=0. Re-enable → counting resumes from 0 and TS_o rises after 8 cycles.
5. Assert Rst_i asynchronously (between clock edges) at TickCount_o=4, TS_o=1 → all outputs 0 immediately. After release, the timer behaves as in scenario 1.
6. Drive the full S0→S1→S2→S3→S0 sequence with a stub FSM (advance on TL/TS alternately) → each phase lasts exactly 20 or 8 cycles plus one state-register cycle, and no phase is skipped.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared encodings for the traffic-light controller and its phase timer.
// Phase codes match the light FSM state register; timer states are local.
// No logic here: types only.
package traffic_pkg;

  // Light phases as encoded by the traffic-light FSM state register
  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } phase_t;

  // Interval timer control states
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUN     = 2'b01,
    EXPIRED = 2'b10
  } timer_state_t;

endpackage

// File: rtl/tick_gen.sv
// Prescaler: divides Clk_i into one-cycle Tick_o pulses every PRESCALE cycles.
// Latency: first tick in the PRESCALE-th running cycle after a clear.
// Backpressure: none; Clear_i or Run_i low parks the prescaler at 0.
module tick_gen #(
  parameter int PRESCALE = 50000000
) (
  input  logic Clk_i,
  input  logic Rst_i,
  input  logic Clear_i,
  input  logic Run_i,
  output logic Tick_o
);

  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] presc_q;

  // A clear in the same cycle as the terminal count suppresses the tick
  assign Tick_o = Run_i & ~Clear_i & (presc_q == LAST);

  // Prescaler counts 0..PRESCALE-1 while running, otherwise held at 0
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      presc_q <= '0;
    end else if (Clear_i || !Run_i) begin
      presc_q <= '0;
    end else if (presc_q == LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + PW'(1);
    end
  end

endmodule

// File: rtl/traffic_timer.sv
// Phase interval timer feeding TS/TL timeout qualifiers to the light FSM.
// Latency: TS after SHORT_TICKS*PRESCALE cycles in RUN, TL after LONG_TICKS*PRESCALE.
// Backpressure: none; any phase change or Restart_i re-times the phase from zero.
module traffic_timer
  import traffic_pkg::*;
#(
  parameter int PRESCALE    = 50000000,
  parameter int SHORT_TICKS = 5,
  parameter int LONG_TICKS  = 25,
  parameter int CNT_W       = 8
) (
  input  logic             Clk_i,
  input  logic             Rst_i,
  input  logic             Enable_i,
  input  logic             Restart_i,
  input  logic [1:0]       CurrentState_i,
  output logic             TS_o,
  output logic             TL_o,
  output logic [CNT_W-1:0] TickCount_o,
  output logic             Busy_o
);

  localparam logic [CNT_W-1:0] SHORT_C   = CNT_W'(SHORT_TICKS);
  localparam logic [CNT_W-1:0] LONG_C    = CNT_W'(LONG_TICKS);
  localparam logic [CNT_W-1:0] LONG_M1_C = CNT_W'(LONG_TICKS - 1);

  timer_state_t     state_q;
  timer_state_t     state_d;
  phase_t           prev_state_q;
  logic [CNT_W-1:0] count_q;
  logic             state_change;
  logic             restart;
  logic             presc_clear;
  logic             presc_run;
  logic             tick;

  // Phase change seen against last cycle's phase; combinational so the
  // timeout outputs drop in the very cycle the light FSM moves.
  assign state_change = (CurrentState_i != prev_state_q);
  assign restart      = state_change | Restart_i;

  // The prescaler restarts whenever the tick count restarts
  assign presc_clear = ~Enable_i | (state_q == IDLE) | restart;
  assign presc_run   = (state_q == RUN);

  tick_gen #(
    .PRESCALE(PRESCALE)
  ) u_tick_gen (
    .Clk_i  (Clk_i),
    .Rst_i  (Rst_i),
    .Clear_i(presc_clear),
    .Run_i  (presc_run),
    .Tick_o (tick)
  );

  // Track the FSM phase of the previous cycle for change detection
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      prev_state_q <= S0;
    end else begin
      prev_state_q <= phase_t'(CurrentState_i);
    end
  end

  // Timer state register
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: disable beats restart, restart beats expiry
  always_comb begin
    state_d = state_q;
    if (!Enable_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN: begin
          if (restart) begin
            state_d = RUN;
          end else if (tick && (count_q == LONG_M1_C)) begin
            state_d = EXPIRED;
          end
        end
        EXPIRED: begin
          if (restart) begin
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Tick counter: clears on disable/idle/restart, saturates at LONG_TICKS
  always_ff @(posedge Clk_i or posedge Rst_i) begin
    if (Rst_i) begin
      count_q <= '0;
    end else if (!Enable_i || (state_q == IDLE) || restart) begin
      count_q <= '0;
    end else if (state_q == EXPIRED) begin
      count_q <= LONG_C;
    end else if (tick) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  // Outputs: timeouts masked while idle and during the phase-change cycle
  always_comb begin
    Busy_o      = (state_q == RUN);
    TickCount_o = count_q;
    TS_o        = 1'b0;
    TL_o        = 1'b0;
    if (!state_change && (state_q != IDLE)) begin
      TS_o = (count_q >= SHORT_C);
      TL_o = (count_q >= LONG_C);
    end
  end

endmodule

// File: tb/tb_traffic_timer.sv
// Self-checking bench for traffic_timer with a small prescale for fast runs.
// Directed scenarios check fixed latencies; a random run checks a reference model.
// Stimulus drives on the falling edge; outputs are sampled on the falling edge.
module tb_traffic_timer;

  localparam int P  = 4;
  localparam int SH = 2;
  localparam int LG = 5;
  localparam int W  = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0;
  logic         restart_i = 1'b0;
  logic [1:0]   cur_drv = 2'b00;
  logic [1:0]   stub_state = 2'b00;
  logic         stub_on = 1'b0;
  logic [1:0]   cur;
  logic         ts;
  logic         tl;
  logic         busy;
  logic [W-1:0] tcnt;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed cycles since the counters were last cleared
  bit         m_run = 1'b0;
  int         m_elapsed = 0;
  logic [1:0] m_prev = 2'b00;

  assign cur = stub_on ? stub_state : cur_drv;

  always #5 clk = ~clk;

  traffic_timer #(
    .PRESCALE(P),
    .SHORT_TICKS(SH),
    .LONG_TICKS(LG),
    .CNT_W(W)
  ) dut (
    .Clk_i(clk),
    .Rst_i(rst),
    .Enable_i(en),
    .Restart_i(restart_i),
    .CurrentState_i(cur),
    .TS_o(ts),
    .TL_o(tl),
    .TickCount_o(tcnt),
    .Busy_o(busy)
  );

  // Reference model: a phase is timed as elapsed cycles, ticks = elapsed / P
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run     <= 1'b0;
      m_elapsed <= 0;
      m_prev    <= 2'b00;
    end else begin
      m_prev <= cur;
      if (!en) begin
        m_run     <= 1'b0;
        m_elapsed <= 0;
      end else if (!m_run) begin
        m_run     <= 1'b1;
        m_elapsed <= 0;
      end else if ((cur != m_prev) || restart_i) begin
        m_elapsed <= 0;
      end else if (m_elapsed < LG * P) begin
        m_elapsed <= m_elapsed + 1;
      end
    end
  end

  // Stub light FSM: S0/S2 leave on TL, S1/S3 leave on TS
  always @(posedge clk) begin
    if (!stub_on) begin
      stub_state <= cur_drv;
    end else if (stub_state[0] == 1'b0) begin
      if (tl) stub_state <= stub_state + 2'd1;
    end else begin
      if (ts) stub_state <= stub_state + 2'd1;
    end
  end

  // Edge counts from the current falling edge until TS and TL first appear
  task automatic measure(output int ts_lat, output int tl_lat);
    ts_lat = -1;
    tl_lat = -1;
    for (int i = 0; i < 200; i++) begin
      if (ts_lat < 0 && ts === 1'b1) ts_lat = i;
      if (tl === 1'b1) begin
        tl_lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({ts, tl, busy, tcnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs got %0h want 0", {ts, tl, busy, tcnt});
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if ({ts, tl, busy, tcnt} !== 11'd0) begin
      errors++;
      $display("FAIL reset_hold_enabled got %0h want 0", {ts, tl, busy, tcnt});
    end
    rst = 1'b0;
  endtask

  task automatic test_expire;
    int tsl;
    int tll;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tcnt !== 8'd0) begin
      errors++;
      $display("FAIL run_entry got busy=%b cnt=%0d want busy=1 cnt=0", busy, tcnt);
    end
    measure(tsl, tll);
    checks++;
    if (tsl != SH * P) begin
      errors++;
      $display("FAIL ts_latency got %0d want %0d", tsl, SH * P);
    end
    checks++;
    if (tll != LG * P) begin
      errors++;
      $display("FAIL tl_latency got %0d want %0d", tll, LG * P);
    end
    for (int i = 0; i < 100; i++) begin
      checks++;
      if (tcnt !== 8'(LG) || busy !== 1'b0 || tl !== 1'b1 || ts !== 1'b1) begin
        errors++;
        $display("FAIL expired_hold cycle %0d got cnt=%0d busy=%b tl=%b ts=%b want cnt=%0d busy=0 tl=1 ts=1",
                 i, tcnt, busy, tl, ts, LG);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_phase_change;
    int tsl;
    int tll;
    cur_drv = 2'b01;
    #1;
    checks++;
    if (ts !== 1'b0 || tl !== 1'b0) begin
      errors++;
      $display("FAIL phase_change_mask got ts=%b tl=%b want 0 0", ts, tl);
    end
    @(negedge clk);
    checks++;
    if (tcnt !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL phase_change_clear got cnt=%0d busy=%b want 0 1", tcnt, busy);
    end
    measure(tsl, tll);
    checks++;
    if (tsl != SH * P) begin
      errors++;
      $display("FAIL phase_change_ts got %0d want %0d", tsl, SH * P);
    end
  endtask

  task automatic test_restart_tick;
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    checks++;
    if (tcnt !== 8'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_from_expired got cnt=%0d busy=%b want 0 1", tcnt, busy);
    end
    // Seven edges later the prescaler sits on its terminal count with one tick counted
    repeat (2 * P - 1) @(negedge clk);
    checks++;
    if (tcnt !== 8'd1) begin
      errors++;
      $display("FAIL pre_tick_count got %0d want 1", tcnt);
    end
    restart_i = 1'b1;
    @(negedge clk);
    checks++;
    if (tcnt !== 8'd0) begin
      errors++;
      $display("FAIL restart_on_tick got %0d want 0", tcnt);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (tcnt !== 8'd0 || ts !== 1'b0) begin
        errors++;
        $display("FAIL restart_held cycle %0d got cnt=%0d ts=%b want 0 0", i, tcnt, ts);
      end
    end
    restart_i = 1'b0;
  endtask

  task automatic test_enable_drop;
    int tsl;
    int tll;
    int k;
    k = 0;
    while (tcnt !== 8'd3 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k != 3 * P) begin
      errors++;
      $display("FAIL count3_latency got %0d want %0d", k, 3 * P);
    end
    en = 1'b0;
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    checks++;
    if (busy !== 1'b0 || ts !== 1'b0 || tcnt !== 8'd0) begin
      errors++;
      $display("FAIL disable_wins got busy=%b ts=%b cnt=%0d want 0 0 0", busy, ts, tcnt);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || tcnt !== 8'd0) begin
      errors++;
      $display("FAIL idle_hold got busy=%b cnt=%0d want 0 0", busy, tcnt);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tcnt !== 8'd0) begin
      errors++;
      $display("FAIL reenable got busy=%b cnt=%0d want 1 0", busy, tcnt);
    end
    measure(tsl, tll);
    checks++;
    if (tsl != SH * P) begin
      errors++;
      $display("FAIL reenable_ts got %0d want %0d", tsl, SH * P);
    end
  endtask

  task automatic test_async_reset;
    int tsl;
    int tll;
    int k;
    restart_i = 1'b1;
    @(negedge clk);
    restart_i = 1'b0;
    k = 0;
    while (tcnt !== 8'd4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (tcnt !== 8'd4 || ts !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got cnt=%0d ts=%b want 4 1", tcnt, ts);
    end
    #2;
    rst = 1'b1;
    cur_drv = 2'b00;
    #1;
    checks++;
    if ({ts, tl, busy, tcnt} !== 11'd0) begin
      errors++;
      $display("FAIL async_reset got %0h want 0", {ts, tl, busy, tcnt});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || tcnt !== 8'd0) begin
      errors++;
      $display("FAIL post_reset_entry got busy=%b cnt=%0d want 1 0", busy, tcnt);
    end
    measure(tsl, tll);
    checks++;
    if (tsl != SH * P || tll != LG * P) begin
      errors++;
      $display("FAIL post_reset_latency got ts=%0d tl=%0d want %0d %0d", tsl, tll, SH * P, LG * P);
    end
  endtask

  task automatic test_stub_fsm;
    int last;
    int clr;
    int nchg;
    int want;
    last = int'(cur);
    clr = -1;
    nchg = 0;
    stub_on = 1'b1;
    for (int i = 0; i < 400 && nchg < 8; i++) begin
      @(negedge clk);
      if (int'(cur) != last) begin
        checks++;
        if (int'(cur) != (last + 1) % 4) begin
          errors++;
          $display("FAIL stub_sequence got %0d want %0d", cur, (last + 1) % 4);
        end
        if (clr >= 0) begin
          // From the edge that clears the counters to the stub's next move
          want = ((last % 2) == 0) ? LG * P + 1 : SH * P + 1;
          checks++;
          if (i - clr != want) begin
            errors++;
            $display("FAIL stub_phase_len phase %0d got %0d want %0d", last, i - clr, want);
          end
        end
        clr = i + 1;
        last = int'(cur);
        nchg++;
      end else if (i == clr) begin
        checks++;
        if (tcnt !== 8'd0) begin
          errors++;
          $display("FAIL stub_phase_clear got %0d want 0", tcnt);
        end
      end
    end
    checks++;
    if (nchg != 8) begin
      errors++;
      $display("FAIL stub_timeout got %0d changes want 8", nchg);
    end
    cur_drv = cur;
    stub_on = 1'b0;
  endtask

  task automatic test_random;
    int mc;
    bit msc;
    logic [10:0] expv;
    int rr;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      mc = m_run ? ((m_elapsed / P > LG) ? LG : m_elapsed / P) : 0;
      msc = (cur != m_prev);
      expv = {m_run && mc >= SH && !msc, m_run && mc >= LG && !msc, m_run && mc < LG, 8'(mc)};
      checks++;
      if ({ts, tl, busy, tcnt} !== expv) begin
        errors++;
        $display("FAIL random_edge cycle %0d got %0h want %0h", n, {ts, tl, busy, tcnt}, expv);
      end
      rr = ((n / 300) % 2 == 0) ? 1 : 6;
      en = ($urandom_range(0, 99) >= 2);
      restart_i = ($urandom_range(0, 99) < rr);
      if ($urandom_range(0, 99) < rr) cur_drv = 2'($urandom_range(0, 3));
      #1;
      msc = (cur != m_prev);
      checks++;
      if ({ts, tl} !== {m_run && mc >= SH && !msc, m_run && mc >= LG && !msc}) begin
        errors++;
        $display("FAIL random_comb cycle %0d got %b%b want %b%b", n, ts, tl,
                 m_run && mc >= SH && !msc, m_run && mc >= LG && !msc);
      end
      if ($urandom_range(0, 399) == 0) begin
        #1 rst = 1'b1;
        #1 rst = 1'b0;
      end
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    test_reset();
    test_expire();
    test_phase_change();
    test_restart_tick();
    test_enable_drop();
    test_async_reset();
    test_stub_fsm();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired got running want finished");
    $fatal(1, "watchdog");
  end

endmodule
